// File: rtl/dccm_mbist_pkg.sv
// Shared definitions for the DCCM memory-test engine.
//   mbist_state_e  : engine state encoding
//   pattern_word() : address-derived test word, optionally inverted
//   access_count() : number of 8-byte accesses covering a DCCM of a given size
package dccm_mbist_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } mbist_state_e;

   // Widest stored word the pattern helper supports; callers truncate.
   localparam int unsigned PAT_W = 64;

   localparam int unsigned DCCM_SIZE_DEFAULT    = 64;
   localparam int unsigned ACCESS_COUNT_DEFAULT = DCCM_SIZE_DEFAULT * 1024 / 8;

   function automatic int unsigned access_count(input int unsigned size_kb);
      return size_kb * 1024 / 8;
   endfunction

   // Zero-extended address, all bits flipped when invert is set.
   function automatic logic [PAT_W-1:0] pattern_word(input logic [PAT_W-1:0] addr,
                                                     input logic             invert);
      return invert ? ~addr : addr;
   endfunction

endpackage

// File: rtl/dccm_mbist_ctl_if.sv
// DCCM read/write port bundle as accepted by the DCCM memory wrapper.
//   master : access initiator (drives strobes, addresses, write data)
//   slave  : memory wrapper (returns read data)
interface dccm_mbist_ctl_if #(
   parameter int unsigned DCCM_BITS        = 16,
   parameter int unsigned DCCM_FDATA_WIDTH = 39
);
   logic                        dccm_wren;
   logic                        dccm_rden;
   logic [DCCM_BITS-1:0]        dccm_wr_addr_lo;
   logic [DCCM_BITS-1:0]        dccm_wr_addr_hi;
   logic [DCCM_BITS-1:0]        dccm_rd_addr_lo;
   logic [DCCM_BITS-1:0]        dccm_rd_addr_hi;
   logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_lo;
   logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_hi;
   logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_lo;
   logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_hi;

   modport master (
      output dccm_wren, dccm_rden,
      output dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_rd_addr_lo, dccm_rd_addr_hi,
      output dccm_wr_data_lo, dccm_wr_data_hi,
      input  dccm_rd_data_lo, dccm_rd_data_hi
   );

   modport slave (
      input  dccm_wren, dccm_rden,
      input  dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_rd_addr_lo, dccm_rd_addr_hi,
      input  dccm_wr_data_lo, dccm_wr_data_hi,
      output dccm_rd_data_lo, dccm_rd_data_hi
   );
endinterface

// File: rtl/dccm_mbist_rdpipe.sv
// Expected-address pipe for outstanding DCCM reads.
//   push/push_addr : read issued this cycle and its lo address
//   flush          : drop every outstanding entry (abort or first failure)
//   out_valid/out_addr : entry whose read data is on the bus this cycle
//   empty          : no reads outstanding
module dccm_mbist_rdpipe #(
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned AW     = 16
) (
   input  logic          clk,
   input  logic          rst_l,
   input  logic          push,
   input  logic [AW-1:0] push_addr,
   input  logic          flush,
   output logic          out_valid,
   output logic [AW-1:0] out_addr,
   output logic          empty
);

   logic [RD_LAT-1:0] vld_q;
   logic [AW-1:0]     adr_q [RD_LAT];

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         vld_q <= '0;
         for (int unsigned i = 0; i < RD_LAT; i++) adr_q[i] <= '0;
      end else begin
         vld_q[0] <= push & ~flush;
         adr_q[0] <= push_addr;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1] & ~flush;
            adr_q[i] <= adr_q[i-1];
         end
      end
   end

   assign out_valid = vld_q[RD_LAT-1];
   assign out_addr  = adr_q[RD_LAT-1];
   assign empty     = ~|vld_q;

endmodule

// File: rtl/dccm_mbist_ctl.sv
// DCCM memory-test initiator. Writes an address-derived pattern over the
// whole DCCM in idle core cycles, reads it back, compares, and reports.
//   clk, rst_l           : clock, asynchronous active-low reset
//   start, abort, invert : test control (invert sampled at start)
//   core_busy            : core owns the DCCM port this cycle
//   dccm                 : DCCM port bundle (master side)
//   busy, done, fail, fail_addr : status, first failing lo address
module dccm_mbist_ctl
   import dccm_mbist_pkg::*;
#(
   parameter int unsigned DCCM_BITS        = 16,
   parameter int unsigned DCCM_FDATA_WIDTH = 39,
   parameter int unsigned DCCM_SIZE        = 64,
   parameter int unsigned RD_LAT           = 1
) (
   input  logic                 clk,
   input  logic                 rst_l,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 invert,
   input  logic                 core_busy,
   dccm_mbist_ctl_if.master     dccm,
   output logic                 busy,
   output logic                 done,
   output logic                 fail,
   output logic [DCCM_BITS-1:0] fail_addr
);

   localparam int unsigned N     = access_count(DCCM_SIZE);
   localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

   mbist_state_e          state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  inv_q, inv_d;
   logic                  fail_q, fail_d;
   logic [DCCM_BITS-1:0]  fail_addr_q, fail_addr_d;
   logic                  aborted_q, aborted_d;

   logic                        active, abort_hit, last;
   logic                        wr_go, rd_go, mism, flush;
   logic [DCCM_BITS-1:0]        a_lo, a_hi;
   logic [DCCM_FDATA_WIDTH-1:0] wd_lo, wd_hi, exp_lo, exp_hi;
   logic                        pipe_valid, pipe_empty;
   logic [DCCM_BITS-1:0]        pipe_addr;

   // Address/data are forced to zero outside WRITE/READ so idle outputs stay 0.
   assign active    = (state_q == WRITE) || (state_q == READ);
   assign abort_hit = abort && active;
   assign last      = (cnt_q == CNT_W'(N - 1));
   assign a_lo      = active ? DCCM_BITS'({cnt_q, 3'b000}) : '0;
   assign a_hi      = active ? a_lo + DCCM_BITS'(4) : '0;
   assign wd_lo     = active ? DCCM_FDATA_WIDTH'(pattern_word(PAT_W'(a_lo), inv_q)) : '0;
   assign wd_hi     = active ? DCCM_FDATA_WIDTH'(pattern_word(PAT_W'(a_hi), inv_q)) : '0;

   assign exp_lo = DCCM_FDATA_WIDTH'(pattern_word(PAT_W'(pipe_addr), inv_q));
   assign exp_hi = DCCM_FDATA_WIDTH'(pattern_word(PAT_W'(pipe_addr + DCCM_BITS'(4)), inv_q));

   // Reads returning in the abort cycle are discarded rather than compared.
   assign mism  = pipe_valid && !abort_hit &&
                  ((dccm.dccm_rd_data_lo != exp_lo) || (dccm.dccm_rd_data_hi != exp_hi));
   assign flush = abort_hit || mism;

   dccm_mbist_rdpipe #(
      .RD_LAT (RD_LAT),
      .AW     (DCCM_BITS)
   ) u_rdpipe (
      .clk       (clk),
      .rst_l     (rst_l),
      .push      (rd_go),
      .push_addr (a_lo),
      .flush     (flush),
      .out_valid (pipe_valid),
      .out_addr  (pipe_addr),
      .empty     (pipe_empty)
   );

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         inv_q       <= 1'b0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         aborted_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         inv_q       <= inv_d;
         fail_q      <= fail_d;
         fail_addr_q <= fail_addr_d;
         aborted_q   <= aborted_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      inv_d       = inv_q;
      fail_d      = fail_q;
      fail_addr_d = fail_addr_q;
      aborted_d   = aborted_q;
      // A mismatch seen this cycle suppresses the read that would otherwise issue.
      wr_go       = (state_q == WRITE) && !core_busy && !abort_hit;
      rd_go       = (state_q == READ) && !core_busy && !abort_hit && !mism;

      if (mism) begin
         fail_d      = 1'b1;
         fail_addr_d = pipe_addr;
      end

      case (state_q)
         IDLE, DONE: begin
            if (start && !abort) begin
               state_d     = WRITE;
               cnt_d       = '0;
               inv_d       = invert;
               fail_d      = 1'b0;
               fail_addr_d = '0;
               aborted_d   = 1'b0;
            end
         end
         WRITE: begin
            if (abort) begin
               state_d   = DRAIN;
               aborted_d = 1'b1;
            end else if (wr_go) begin
               if (last) begin
                  state_d = READ;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         READ: begin
            if (abort) begin
               state_d   = DRAIN;
               aborted_d = 1'b1;
            end else if (mism) begin
               state_d = DRAIN;
            end else if (rd_go) begin
               if (last) state_d = DRAIN;
               else      cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         DRAIN: begin
            if (pipe_empty) begin
               state_d   = aborted_q ? IDLE : DONE;
               aborted_d = 1'b0;
               if (aborted_q) fail_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign dccm.dccm_wren       = wr_go;
   assign dccm.dccm_rden       = rd_go;
   assign dccm.dccm_wr_addr_lo = a_lo;
   assign dccm.dccm_wr_addr_hi = a_hi;
   assign dccm.dccm_rd_addr_lo = a_lo;
   assign dccm.dccm_rd_addr_hi = a_hi;
   assign dccm.dccm_wr_data_lo = wd_lo;
   assign dccm.dccm_wr_data_hi = wd_hi;

   assign busy      = (state_q == WRITE) || (state_q == READ) || (state_q == DRAIN);
   assign done      = (state_q == DONE);
   assign fail      = fail_q;
   assign fail_addr = fail_addr_q;

endmodule

// File: tb/tb_dccm_mbist_ctl.sv
// Self-checking bench for dccm_mbist_ctl: 1 KB DCCM (128 accesses),
// read latency 2, with a simple DCCM memory model that can corrupt one word.
module tb_dccm_mbist_ctl;

   localparam int unsigned BITS   = 16;
   localparam int unsigned FW     = 39;
   localparam int unsigned SIZE   = 1;
   localparam int unsigned RD_LAT = 2;
   localparam int          N      = 128;

   logic            clk       = 1'b0;
   logic            rst_l     = 1'b1;
   logic            start     = 1'b0;
   logic            abort     = 1'b0;
   logic            invert    = 1'b0;
   logic            core_busy = 1'b0;
   logic            busy, done, fail;
   logic [BITS-1:0] fail_addr;

   int n_checks = 0;
   int n_pass   = 0;

   dccm_mbist_ctl_if #(.DCCM_BITS(BITS), .DCCM_FDATA_WIDTH(FW)) mif ();

   dccm_mbist_ctl #(
      .DCCM_BITS        (BITS),
      .DCCM_FDATA_WIDTH (FW),
      .DCCM_SIZE        (SIZE),
      .RD_LAT           (RD_LAT)
   ) dut (
      .clk       (clk),
      .rst_l     (rst_l),
      .start     (start),
      .abort     (abort),
      .invert    (invert),
      .core_busy (core_busy),
      .dccm      (mif),
      .busy      (busy),
      .done      (done),
      .fail      (fail),
      .fail_addr (fail_addr)
   );

   always #5 clk = ~clk;

   // Memory model: word-indexed store, two-stage read return.
   logic [FW-1:0]   mem [256];
   logic [FW-1:0]   s0_lo = '0, s0_hi = '0, s1_lo = '0, s1_hi = '0;
   logic            corrupt_en   = 1'b0;
   logic [BITS-1:0] corrupt_addr = '0;

   always @(posedge clk) begin
      if (mif.dccm_wren) begin
         mem[mif.dccm_wr_addr_lo[9:2]] <= mif.dccm_wr_data_lo;
         mem[mif.dccm_wr_addr_hi[9:2]] <= mif.dccm_wr_data_hi;
      end
      if (mif.dccm_rden) begin
         s0_lo <= mem[mif.dccm_rd_addr_lo[9:2]] ^
                  ((corrupt_en && mif.dccm_rd_addr_lo == corrupt_addr) ? 39'h8 : 39'h0);
         s0_hi <= mem[mif.dccm_rd_addr_hi[9:2]];
      end
      s1_lo <= s0_lo;
      s1_hi <= s0_hi;
   end

   assign mif.dccm_rd_data_lo = s1_lo;
   assign mif.dccm_rd_data_hi = s1_hi;

   function automatic logic [FW-1:0] exp_word(input int a, input logic inv);
      logic [FW-1:0] w;
      w = FW'(a);
      return inv ? ~w : w;
   endfunction

   // Runs one test from a start pulse until done (or busy drops), logging
   // every strobe at the negedge and tallying protocol/order/data errors.
   task automatic run_test(input logic inv, input bit stall, input int abort_at,
                           input int mid_start,
                           output int cyc, output int nwr, output int nrd,
                           output int proto_err, output int order_err, output int data_err,
                           output logic [FW-1:0] cap_lo, output logic [FW-1:0] cap_hi,
                           output bit timeout);
      bit abort_sent;
      cyc = 0; nwr = 0; nrd = 0; proto_err = 0; order_err = 0; data_err = 0;
      cap_lo = '0; cap_hi = '0; timeout = 1'b1; abort_sent = 1'b0;
      invert = inv;
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      invert = ~inv;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (done || !busy) begin
            timeout = 1'b0;
            break;
         end
         if (mif.dccm_wren) begin
            if (core_busy || mif.dccm_rden) proto_err++;
            if (mif.dccm_wr_addr_lo !== BITS'(nwr * 8) || mif.dccm_wr_addr_hi !== BITS'(nwr * 8 + 4) ||
                mif.dccm_rd_addr_lo !== mif.dccm_wr_addr_lo) order_err++;
            if (mif.dccm_wr_data_lo !== exp_word(nwr * 8, inv) ||
                mif.dccm_wr_data_hi !== exp_word(nwr * 8 + 4, inv)) data_err++;
            if (nwr == 2) begin
               cap_lo = mif.dccm_wr_data_lo;
               cap_hi = mif.dccm_wr_data_hi;
            end
            nwr++;
         end
         if (mif.dccm_rden) begin
            if (core_busy) proto_err++;
            if (mif.dccm_rd_addr_lo !== BITS'(nrd * 8) || mif.dccm_rd_addr_hi !== BITS'(nrd * 8 + 4) ||
                mif.dccm_wr_addr_hi !== mif.dccm_rd_addr_hi) order_err++;
            nrd++;
         end
         @(posedge clk); #1;
         cyc++;
         core_busy = stall && (cyc % 3 == 2);
         start     = (cyc == mid_start);
         abort     = 1'b0;
         if (abort_at >= 0 && !abort_sent && nrd == abort_at) begin
            abort      = 1'b1;
            abort_sent = 1'b1;
         end
      end
      core_busy = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst_l = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({busy, done, fail} !== 3'b000) $display("FAIL reset_status: got %b want 000", {busy, done, fail});
      else n_pass++;
      n_checks++;
      if (fail_addr !== '0) $display("FAIL reset_fail_addr: got %h want 0", fail_addr);
      else n_pass++;
      n_checks++;
      if ({mif.dccm_wren, mif.dccm_rden} !== 2'b00) $display("FAIL reset_strobes: got %b want 00", {mif.dccm_wren, mif.dccm_rden});
      else n_pass++;
      n_checks++;
      if (mif.dccm_wr_addr_hi !== '0 || mif.dccm_wr_data_hi !== '0)
         $display("FAIL reset_addr_data: got addr_hi %h data_hi %h want 0 0", mif.dccm_wr_addr_hi, mif.dccm_wr_data_hi);
      else n_pass++;
      rst_l = 1'b1;
      @(posedge clk); #1;
   endtask

   // Clean pass; a start pulse mid-run must be ignored.
   task automatic test_pass();
      int cyc, nwr, nrd, pe, oe, de; logic [FW-1:0] cl, ch; bit to;
      run_test(1'b0, 1'b0, -1, 50, cyc, nwr, nrd, pe, oe, de, cl, ch, to);
      n_checks++;
      if (to || cyc !== 257 + RD_LAT) $display("FAIL pass_done_cycle: got %0d (timeout %0b) want %0d", cyc, to, 257 + RD_LAT);
      else n_pass++;
      n_checks++;
      if (nwr !== N || nrd !== N) $display("FAIL pass_counts: got wr %0d rd %0d want %0d %0d", nwr, nrd, N, N);
      else n_pass++;
      n_checks++;
      if (pe + oe + de !== 0) $display("FAIL pass_sequence: got proto %0d order %0d data %0d want 0 0 0", pe, oe, de);
      else n_pass++;
      n_checks++;
      if (fail !== 1'b0 || busy !== 1'b0) $display("FAIL pass_status: got fail %b busy %b want 0 0", fail, busy);
      else n_pass++;
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (done !== 1'b1) $display("FAIL pass_done_sticky: got %b want 1", done);
      else n_pass++;
   endtask

   task automatic test_fail();
      int cyc, nwr, nrd, pe, oe, de; logic [FW-1:0] cl, ch; bit to;
      corrupt_en   = 1'b1;
      corrupt_addr = 16'h0120;
      run_test(1'b0, 1'b0, -1, -1, cyc, nwr, nrd, pe, oe, de, cl, ch, to);
      corrupt_en = 1'b0;
      n_checks++;
      if (to || done !== 1'b1) $display("FAIL fail_done: got done %b timeout %0b want 1 0", done, to);
      else n_pass++;
      n_checks++;
      if (fail !== 1'b1) $display("FAIL fail_flag: got %b want 1", fail);
      else n_pass++;
      n_checks++;
      if (fail_addr !== 16'h0120) $display("FAIL fail_addr: got %h want 0120", fail_addr);
      else n_pass++;
      // Reads 0x000..0x128 issue (36 + RD_LAT); none after the mismatch cycle.
      n_checks++;
      if (nrd !== 38) $display("FAIL fail_read_count: got %0d want 38", nrd);
      else n_pass++;
      n_checks++;
      if (nwr !== N || pe + oe !== 0) $display("FAIL fail_sequence: got wr %0d proto %0d order %0d want %0d 0 0", nwr, pe, oe, N);
      else n_pass++;
   endtask

   task automatic test_invert();
      int cyc, nwr, nrd, pe, oe, de; logic [FW-1:0] cl, ch; bit to;
      run_test(1'b1, 1'b0, -1, -1, cyc, nwr, nrd, pe, oe, de, cl, ch, to);
      n_checks++;
      if (cl !== 39'h7F_FFFF_FFEF) $display("FAIL invert_lo_0x10: got %h want 7fffffffef", cl);
      else n_pass++;
      n_checks++;
      if (ch !== 39'h7F_FFFF_FFEB) $display("FAIL invert_hi_0x14: got %h want 7fffffffeb", ch);
      else n_pass++;
      n_checks++;
      if (de !== 0) $display("FAIL invert_data: got %0d bad writes want 0", de);
      else n_pass++;
      n_checks++;
      if (to || done !== 1'b1 || fail !== 1'b0) $display("FAIL invert_result: got done %b fail %b want 1 0", done, fail);
      else n_pass++;
   endtask

   task automatic test_stall();
      int cyc, nwr, nrd, pe, oe, de; logic [FW-1:0] cl, ch; bit to;
      run_test(1'b0, 1'b1, -1, -1, cyc, nwr, nrd, pe, oe, de, cl, ch, to);
      n_checks++;
      if (pe !== 0) $display("FAIL stall_strobe_vs_busy: got %0d violations want 0", pe);
      else n_pass++;
      n_checks++;
      if (nwr !== N || nrd !== N || oe !== 0) $display("FAIL stall_order: got wr %0d rd %0d order %0d want %0d %0d 0", nwr, nrd, oe, N, N);
      else n_pass++;
      n_checks++;
      if (to || done !== 1'b1 || fail !== 1'b0) $display("FAIL stall_result: got done %b fail %b want 1 0", done, fail);
      else n_pass++;
   endtask

   task automatic test_abort();
      int cyc, nwr, nrd, pe, oe, de, strobes; logic [FW-1:0] cl, ch; bit to;
      // 0x130 is one of the two reads in flight when abort hits; it must not be compared.
      corrupt_en   = 1'b1;
      corrupt_addr = 16'h0130;
      run_test(1'b0, 1'b0, 40, -1, cyc, nwr, nrd, pe, oe, de, cl, ch, to);
      repeat (3) @(posedge clk);
      #1;
      corrupt_en = 1'b0;
      n_checks++;
      if (to || nrd !== 40) $display("FAIL abort_read_count: got %0d (timeout %0b) want 40", nrd, to);
      else n_pass++;
      n_checks++;
      if ({busy, done, fail} !== 3'b000) $display("FAIL abort_idle: got busy/done/fail %b want 000", {busy, done, fail});
      else n_pass++;
      strobes = 0;
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (mif.dccm_wren || mif.dccm_rden || busy) strobes++;
      end
      n_checks++;
      if (strobes !== 0 || done !== 1'b0) $display("FAIL abort_start_idle: got %0d active cycles done %b want 0 0", strobes, done);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int cyc, nwr, nrd, pe, oe, de, strobes; logic [FW-1:0] cl, ch; bit to;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (20) @(posedge clk);
      #3 rst_l = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, fail, mif.dccm_wren, mif.dccm_rden} !== 5'b0)
         $display("FAIL midreset_status: got %b want 00000", {busy, done, fail, mif.dccm_wren, mif.dccm_rden});
      else n_pass++;
      n_checks++;
      if (mif.dccm_wr_addr_lo !== '0 || mif.dccm_wr_data_lo !== '0)
         $display("FAIL midreset_addr_data: got %h %h want 0 0", mif.dccm_wr_addr_lo, mif.dccm_wr_data_lo);
      else n_pass++;
      strobes = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (mif.dccm_wren || mif.dccm_rden) strobes++;
      end
      @(posedge clk); #1;
      rst_l = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (mif.dccm_wren || mif.dccm_rden) strobes++;
      end
      n_checks++;
      if (strobes !== 0) $display("FAIL midreset_no_strobes: got %0d want 0", strobes);
      else n_pass++;
      @(posedge clk); #1;
      run_test(1'b0, 1'b0, -1, -1, cyc, nwr, nrd, pe, oe, de, cl, ch, to);
      n_checks++;
      if (to || cyc !== 257 + RD_LAT || fail !== 1'b0) $display("FAIL midreset_rerun: got cycle %0d fail %b want %0d 0", cyc, fail, 257 + RD_LAT);
      else n_pass++;
      n_checks++;
      if (nwr !== N || nrd !== N || pe + oe + de !== 0)
         $display("FAIL midreset_rerun_seq: got wr %0d rd %0d errs %0d want %0d %0d 0", nwr, nrd, pe + oe + de, N, N);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_pass();
      test_fail();
      test_invert();
      test_stall();
      test_abort();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
